jpeg_quantizer_pipe: RTL and testbench
======================================

JPEG_QUANTIZER_PIPE -- requirements
Module: jpeg_quantizer_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning signed DCT coefficient input width.
REQ-002 The block SHALL have parameter OUT_W, default 16, meaning signed quantized output width.
REQ-003 The block SHALL have parameter FRAC_W, default 16, meaning reciprocal fraction bits.
REQ-004 The block SHALL have parameter ZIGZAG, default 0, meaning input order: 0 raster, 1 zigzag.
REQ-005 The block SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1, meaning coefficient present.
REQ-008 The block SHALL have port in_ready, output, 1, meaning block can accept a coefficient.
REQ-009 The block SHALL have port in_data, input, DATA_W, meaning signed DCT coefficient.
REQ-010 The block SHALL have port tbl_sel, input, 1, meaning table select: 0 luma, 1 chroma (JPEG Annex K).
REQ-011 The block SHALL have port bypass, input, 1, meaning force divisor 1.
REQ-012 The block SHALL have port out_valid, output, 1, meaning result present.
REQ-013 The block SHALL have port out_ready, input, 1, meaning downstream accepts.
REQ-014 The block SHALL have port out_data, output, OUT_W, meaning signed quantized coefficient.
REQ-015 The block SHALL have port out_index, output, 6, meaning coefficient index within block (arrival order).
REQ-016 The block SHALL have port out_last, output, 1, meaning high with out_index 63.
REQ-017 The block SHALL have port block_done, output, 1, meaning one-cycle pulse when the last coefficient transfers.
REQ-018 The block SHALL have port q_monitor, output, 8, meaning divisor used for the current stage-1 coefficient.

Function
REQ-019 A transfer SHALL occur on a cycle with valid and ready both high, on each side independently.
REQ-020 The block SHALL be a 3-stage pipeline: S1 table lookup, S2 multiply, S3 round/saturate; out_valid SHALL rise 3 cycles after the input transfer when there is no stall.
REQ-021 Stall: while out_valid=1 and out_ready=0, all stages SHALL hold and in_ready SHALL be 0; otherwise in_ready SHALL be 1.
REQ-022 At full throughput the block SHALL sustain one coefficient per cycle with no bubbles.
REQ-023 A 6-bit index counter SHALL increment on each input transfer and wrap from 63 to 0.
REQ-024 tbl_sel and bypass SHALL be latched on the transfer at index 0 and held for the whole block; changes mid-block SHALL be ignored.
REQ-025 Table position: with ZIGZAG=0 it SHALL be the index; with ZIGZAG=1 it SHALL be the raster position of zigzag index k (e.g. k=2 -> 8, k=63 -> 63).
REQ-026 A reciprocal ROM SHALL hold R(q) = floor((2^FRAC_W + q/2) / q) for every table entry; bypass SHALL give q=1 and R=2^FRAC_W.
REQ-027 Result SHALL be sign(x) * ((|x| * R + 2^(FRAC_W-1)) >> FRAC_W), i.e. round half away from zero; the product SHALL be DATA_W+FRAC_W+1 bits with no overflow.
REQ-028 A result outside the OUT_W signed range SHALL saturate to max or min; -2^(DATA_W-1) SHALL be handled without overflow of |x|.
REQ-029 out_index and out_last SHALL travel with their data through the pipeline.
REQ-030 block_done SHALL be high exactly on the cycle the out_last transfer occurs.
REQ-031 No division operator SHALL be used; the ROMs SHALL be constant case tables.

Reset
REQ-032 On rst=1 at a clock edge, the block SHALL clear out_valid, out_last and block_done to 0, out_data and out_index to 0, the counter to 0, all stage valids to 0, and the latched tbl_sel and bypass to 0.
REQ-033 During reset in_ready SHALL be 0; it SHALL be 1 on the first cycle after rst deasserts.
REQ-034 Reset mid-block SHALL discard the partial block and in-flight data; the next transfer SHALL be index 0.

Verification
REQ-035 Luma, raster, index 0 (q=16), x=100 -> out_data 6; x=-100 -> -6; x=8 -> 1; x=-8 -> -1.
REQ-036 64 coefficients back-to-back with out_ready=1 -> 64 outputs on consecutive cycles, first 3 cycles after first input; out_last and block_done at index 63 only.
REQ-037 out_ready=0 for 5 cycles mid-block -> out_data held stable, in_ready=0, no loss or duplication; order preserved.
REQ-038 tbl_sel=1 at index 0 toggled to 0 at index 10 -> chroma table (q=17 at index 0) used for whole block: x=170 -> 10.
REQ-039 ZIGZAG=1, index 2, luma, x=120 -> divisor 12 (raster 8) -> 10; bypass=1, x=-32768, OUT_W=8 -> -128 saturated.
REQ-040 rst pulsed at index 30 -> outputs cleared; next block starts at index 0 with correct results.

Source files
------------

// File: rtl/jpeg_quantizer_pipe.sv
// JPEG coefficient quantizer: Annex K table lookup, reciprocal multiply,
// round-half-away-from-zero and saturate, as a 3-stage valid/ready pipeline.
module jpeg_quantizer_pipe #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 16,
  parameter int FRAC_W = 16,
  parameter int ZIGZAG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              tbl_sel,
  input  logic              bypass,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [5:0]        out_index,
  output logic              out_last,
  output logic              block_done,
  output logic [7:0]        q_monitor
);
  localparam int P  = DATA_W + FRAC_W + 1;
  localparam int RW = FRAC_W + 1;
  localparam logic [P-1:0] HALF = P'(1) << (FRAC_W - 1);
  localparam logic [P-1:0] LIM  = P'(1) << (OUT_W - 1);
  localparam logic [OUT_W-1:0] SMIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] SMAX = {1'b0, {(OUT_W-1){1'b1}}};

  // Shift-subtract evaluation of floor((2^F + q/2) / q); every call
  // below passes a literal, so each ROM arm folds to a constant.
  function automatic logic [RW-1:0] rc(input int q);
    logic [RW:0] num;
    logic [RW:0] quo;
    int rem;
    num = '0;
    num[FRAC_W] = 1'b1;
    num = num + (RW+1)'(q >> 1);
    quo = '0;
    rem = 0;
    for (int i = RW; i >= 0; i--) begin
      rem = rem * 2 + int'(num[i]);
      if (rem >= q) begin
        rem = rem - q;
        quo[i] = 1'b1;
      end
    end
    return quo[RW-1:0];
  endfunction

  function automatic int q_luma(input int p);
    case (p)
      0: return 16;  1: return 11;  2: return 10;  3: return 16;
      4: return 24;  5: return 40;  6: return 51;  7: return 61;
      8: return 12;  9: return 12;  10: return 14; 11: return 19;
      12: return 26; 13: return 58; 14: return 60; 15: return 55;
      16: return 14; 17: return 13; 18: return 16; 19: return 24;
      20: return 40; 21: return 57; 22: return 69; 23: return 56;
      24: return 14; 25: return 17; 26: return 22; 27: return 29;
      28: return 51; 29: return 87; 30: return 80; 31: return 62;
      32: return 18; 33: return 22; 34: return 37; 35: return 56;
      36: return 68; 37: return 109; 38: return 103; 39: return 77;
      40: return 24; 41: return 35; 42: return 55; 43: return 64;
      44: return 81; 45: return 104; 46: return 113; 47: return 92;
      48: return 49; 49: return 64; 50: return 78; 51: return 87;
      52: return 103; 53: return 121; 54: return 120; 55: return 101;
      56: return 72; 57: return 92; 58: return 95; 59: return 98;
      60: return 112; 61: return 100; 62: return 103; 63: return 99;
      default: return 1;
    endcase
  endfunction

  function automatic int q_chroma(input int p);
    case (p)
      0: return 17;  1: return 18;  2: return 24;  3: return 47;
      8: return 18;  9: return 21;  10: return 26; 11: return 66;
      16: return 24; 17: return 26; 18: return 56;
      24: return 47; 25: return 66;
      default: return 99;
    endcase
  endfunction

  function automatic int zz(input int k);
    case (k)
      0: return 0;   1: return 1;   2: return 8;   3: return 16;
      4: return 9;   5: return 2;   6: return 3;   7: return 10;
      8: return 17;  9: return 24;  10: return 32; 11: return 25;
      12: return 18; 13: return 11; 14: return 4;  15: return 5;
      16: return 12; 17: return 19; 18: return 26; 19: return 33;
      20: return 40; 21: return 48; 22: return 41; 23: return 34;
      24: return 27; 25: return 20; 26: return 13; 27: return 6;
      28: return 7;  29: return 14; 30: return 21; 31: return 28;
      32: return 35; 33: return 42; 34: return 49; 35: return 56;
      36: return 57; 37: return 50; 38: return 43; 39: return 36;
      40: return 29; 41: return 22; 42: return 15; 43: return 23;
      44: return 30; 45: return 37; 46: return 44; 47: return 51;
      48: return 58; 49: return 59; 50: return 52; 51: return 45;
      52: return 38; 53: return 31; 54: return 39; 55: return 46;
      56: return 53; 57: return 60; 58: return 61; 59: return 54;
      60: return 47; 61: return 55; 62: return 62; 63: return 63;
      default: return 0;
    endcase
  endfunction

  function automatic logic [RW-1:0] r_rom(input int q);
    case (q)
      10: return rc(10);   11: return rc(11);   12: return rc(12);
      13: return rc(13);   14: return rc(14);   16: return rc(16);
      17: return rc(17);   18: return rc(18);   19: return rc(19);
      21: return rc(21);   22: return rc(22);   24: return rc(24);
      26: return rc(26);   29: return rc(29);   35: return rc(35);
      37: return rc(37);   40: return rc(40);   47: return rc(47);
      49: return rc(49);   51: return rc(51);   55: return rc(55);
      56: return rc(56);   57: return rc(57);   58: return rc(58);
      60: return rc(60);   61: return rc(61);   62: return rc(62);
      64: return rc(64);   66: return rc(66);   68: return rc(68);
      69: return rc(69);   72: return rc(72);   77: return rc(77);
      78: return rc(78);   80: return rc(80);   81: return rc(81);
      87: return rc(87);   92: return rc(92);   95: return rc(95);
      98: return rc(98);   99: return rc(99);   100: return rc(100);
      101: return rc(101); 103: return rc(103); 104: return rc(104);
      109: return rc(109); 112: return rc(112); 113: return rc(113);
      120: return rc(120); 121: return rc(121);
      default: return rc(1);
    endcase
  endfunction

  logic              stall;
  logic              in_fire;
  logic [5:0]        cnt;
  logic              sel_l;
  logic              byp_l;
  logic              sel_c;
  logic              byp_c;
  logic [5:0]        pos;
  logic [7:0]        q_c;
  logic [RW-1:0]     r_c;
  logic              neg_c;
  logic [DATA_W-1:0] mag_c;

  logic              s1_v;
  logic              s1_neg;
  logic [DATA_W-1:0] s1_mag;
  logic [RW-1:0]     s1_r;
  logic [7:0]        s1_q;
  logic [5:0]        s1_idx;

  logic              s2_v;
  logic              s2_neg;
  logic [P-1:0]      s2_prod;
  logic [5:0]        s2_idx;

  logic [P-1:0]      rnd;
  logic [OUT_W-1:0]  sat;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~rst & ~stall;
  assign in_fire  = in_valid & in_ready;

  // Index 0 uses the live selects; the rest of the block uses the latched copy.
  assign sel_c = (cnt == 6'd0) ? tbl_sel : sel_l;
  assign byp_c = (cnt == 6'd0) ? bypass : byp_l;
  assign neg_c = in_data[DATA_W-1];
  assign mag_c = neg_c ? (DATA_W'(0) - in_data) : in_data;

  always_comb begin
    pos = (ZIGZAG != 0) ? 6'(zz(int'(cnt))) : cnt;
    q_c = byp_c ? 8'd1
        : 8'(sel_c ? q_chroma(int'(pos)) : q_luma(int'(pos)));
    r_c = r_rom(int'(q_c));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      sel_l <= 1'b0;
      byp_l <= 1'b0;
    end else if (in_fire) begin
      cnt <= cnt + 6'd1;
      if (cnt == 6'd0) begin
        sel_l <= tbl_sel;
        byp_l <= bypass;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_neg <= 1'b0;
      s1_mag <= '0;
      s1_r   <= '0;
      s1_q   <= '0;
      s1_idx <= '0;
    end else if (!stall) begin
      s1_v <= in_fire;
      if (in_fire) begin
        s1_neg <= neg_c;
        s1_mag <= mag_c;
        s1_r   <= r_c;
        s1_q   <= q_c;
        s1_idx <= cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v    <= 1'b0;
      s2_neg  <= 1'b0;
      s2_prod <= '0;
      s2_idx  <= '0;
    end else if (!stall) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_neg  <= s1_neg;
        s2_prod <= P'(s1_mag) * P'(s1_r);
        s2_idx  <= s1_idx;
      end
    end
  end

  always_comb begin
    rnd = (s2_prod + HALF) >> FRAC_W;
    sat = '0;
    unique case (1'b1)
      s2_neg && (rnd > LIM):    sat = SMIN;
      s2_neg && !(rnd > LIM):   sat = OUT_W'(P'(0) - rnd);
      !s2_neg && (rnd >= LIM):  sat = SMAX;
      !s2_neg && !(rnd >= LIM): sat = OUT_W'(rnd);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else if (!stall) begin
      out_valid <= s2_v;
      out_last  <= s2_v & (s2_idx == 6'd63);
      if (s2_v) begin
        out_data  <= sat;
        out_index <= s2_idx;
      end
    end
  end

  assign block_done = out_valid & out_ready & out_last;
  assign q_monitor  = s1_q;

endmodule

// File: tb/tb_jpeg_quantizer_pipe.sv
// Directed bench for jpeg_quantizer_pipe: raster/16-bit instance plus a
// zigzag/8-bit-output instance sharing the same stimulus.
module tb_jpeg_quantizer_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_ready2;
  logic [15:0] in_data;
  logic        tbl_sel;
  logic        bypass;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [5:0]  out_index;
  logic        out_last;
  logic        block_done;
  logic [7:0]  q_monitor;
  logic        out_valid2;
  logic [7:0]  out_data2;
  logic [5:0]  out_index2;
  logic        out_last2;
  logic        block_done2;
  logic [7:0]  q_monitor2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_cyc = 0;
  int c0 = 0;
  int m_data[$];
  int m_idx[$];
  int m_cyc[$];
  int m_last[$];
  int m_done[$];
  int m2_data[$];
  int b[64];

  jpeg_quantizer_pipe #(
    .DATA_W(16), .OUT_W(16), .FRAC_W(16), .ZIGZAG(0)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .tbl_sel(tbl_sel), .bypass(bypass),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last),
    .block_done(block_done), .q_monitor(q_monitor)
  );

  jpeg_quantizer_pipe #(
    .DATA_W(16), .OUT_W(8), .FRAC_W(16), .ZIGZAG(1)
  ) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .tbl_sel(tbl_sel), .bypass(bypass),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_index(out_index2), .out_last(out_last2),
    .block_done(block_done2), .q_monitor(q_monitor2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      m_data.push_back(int'($signed(out_data)));
      m_idx.push_back(int'(out_index));
      m_cyc.push_back(cyc);
      m_last.push_back(int'(out_last));
      m_done.push_back(int'(block_done));
    end
    if (out_valid2 && out_ready)
      m2_data.push_back(int'($signed(out_data2)));
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear();
    m_data.delete();
    m_idx.delete();
    m_cyc.delete();
    m_last.delete();
    m_done.delete();
    m2_data.delete();
  endtask

  task automatic send(input int x, input logic ts, input logic bp);
    bit ok;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = 16'(x);
    tbl_sel = ts;
    bypass = bp;
    do begin
      @(negedge clk);
      ok = in_ready;
      t_cyc = cyc;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int n);
    int w;
    w = 0;
    while (m_idx.size() < n && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk(tag, m_idx.size(), n);
  endtask

  task automatic order(input string tag);
    int bad;
    bad = 0;
    foreach (m_idx[i]) begin
      if (m_idx[i] != (i % 64)) bad++;
      if (m_last[i] != int'((i % 64) == 63)) bad++;
      if (m_done[i] != int'((i % 64) == 63)) bad++;
    end
    chk(tag, bad, 0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    tbl_sel = 1'b0;
    bypass = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_block_done", block_done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);
    @(posedge clk);
    #1;

    // Block 1: luma, raster, back-to-back.
    clear();
    foreach (b[k]) b[k] = 0;
    b[0] = 100; b[1] = -2000; b[2] = 120; b[3] = -100;
    b[5] = -70; b[18] = 8; b[63] = 1000;
    for (int k = 0; k < 64; k++) begin
      send(b[k], 1'b0, 1'b0);
      if (k == 0) c0 = t_cyc;
    end
    drain("b1_count", 64);
    chk("b1_latency", m_cyc[0] - c0, 3);
    chk("b1_back_to_back", m_cyc[63] - m_cyc[0], 63);
    order("b1_order_last_done");
    chk("b1_x100", m_data[0], 6);
    chk("b1_xm2000_q11", m_data[1], -182);
    chk("b1_x120_q10", m_data[2], 12);
    chk("b1_xm100", m_data[3], -6);
    chk("b1_xm70_q40", m_data[5], -2);
    chk("b1_x8", m_data[18], 1);
    chk("b1_zero", m_data[4], 0);
    chk("b1_x1000_q99", m_data[63], 10);
    chk("zz_idx0", m2_data[0], 6);
    chk("zz_idx2_q12", m2_data[2], 10);

    // Block 2: bypass latched at index 0, stall mid-block.
    clear();
    foreach (b[k]) b[k] = (k % 2 == 1) ? -(k * 3) : k * 5;
    b[40] = -32768;
    b[41] = 32767;
    for (int k = 0; k < 20; k++) begin
      send(b[k], 1'b0, k == 0);
      if (k == 0) chk("b2_q_monitor_bypass", q_monitor, 1);
    end
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_hold_data", $signed(out_data), -51);
      chk("stall_hold_index", out_index, 17);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int k = 20; k < 64; k++) send(b[k], 1'b0, 1'b0);
    drain("b2_count", 64);
    order("b2_order_last_done");
    begin
      int bad;
      bad = 0;
      for (int k = 0; k < 64; k++)
        if (m_data[k] != b[k]) bad++;
      chk("b2_bypass_values", bad, 0);
    end
    chk("b2_min16", m_data[40], -32768);
    chk("sat8_min", m2_data[40], -128);
    chk("sat8_max", m2_data[41], 127);

    // Block 3: chroma at index 0, selects toggled mid-block.
    clear();
    foreach (b[k]) b[k] = 0;
    b[0] = 170; b[10] = 260; b[63] = -1000;
    for (int k = 0; k < 64; k++) begin
      send(b[k], (k < 10), (k >= 10));
      if (k == 0) chk("b3_q_monitor_chroma", q_monitor, 17);
    end
    drain("b3_count", 64);
    chk("b3_x170_q17", m_data[0], 10);
    chk("b3_x260_q26", m_data[10], 10);
    chk("b3_xm1000_q99", m_data[63], -10);

    // Block 4: reset at index 30.
    for (int k = 0; k < 30; k++) send(50, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_index", out_index, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready_after", in_ready, 1);
    repeat (6) @(posedge clk);
    #1;
    chk("mid_rst_flushed", m_idx.size(), 0);

    // Block 5: fresh block after reset.
    foreach (b[k]) b[k] = 0;
    b[0] = -8; b[3] = -100; b[18] = 8;
    for (int k = 0; k < 64; k++) send(b[k], 1'b0, 1'b0);
    drain("b5_count", 64);
    chk("b5_first_index", m_idx[0], 0);
    order("b5_order_last_done");
    chk("b5_xm8", m_data[0], -1);
    chk("b5_xm100", m_data[3], -6);
    chk("b5_x8", m_data[18], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
